// File: rtl/sequencer_rw_mgr_pkg.sv
// Shared types and constants for the rw_mgr Avalon command-queue front-end:
// region decode, FSM state encodings and STATUS word layout.
package sequencer_rw_mgr_pkg;

  typedef enum logic [2:0] {
    RGN_CMD,
    RGN_CONFIG,
    RGN_CSTATE,
    RGN_STATUS,
    RGN_NONE
  } region_e;

  localparam logic [4:0] RGN_CODE_CMD    = 5'b01000;
  localparam logic [4:0] RGN_CODE_CONFIG = 5'b01001;
  localparam logic [4:0] RGN_CODE_CSTATE = 5'b01010;
  localparam logic [4:0] RGN_CODE_STATUS = 5'b01011;

  typedef enum logic {
    DISP_IDLE,
    DISP_EXEC
  } disp_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_DONE
  } rd_state_e;

  localparam int ST_OCC_LSB  = 0;
  localparam int ST_OCC_MSB  = 7;
  localparam int ST_BUSY     = 8;
  localparam int ST_TIMEOUT  = 9;
  localparam int ST_SPURIOUS = 10;
  localparam int ST_FULL     = 11;

  function automatic region_e decode_region(input logic [4:0] code);
    region_e rgn;
    case (code)
      RGN_CODE_CMD:    rgn = RGN_CMD;
      RGN_CODE_CONFIG: rgn = RGN_CONFIG;
      RGN_CODE_CSTATE: rgn = RGN_CSTATE;
      RGN_CODE_STATUS: rgn = RGN_STATUS;
      default:         rgn = RGN_NONE;
    endcase
    return rgn;
  endfunction

endpackage

// File: rtl/sequencer_rw_mgr_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO. Flush can optionally
// retain the head entry, which is the command currently being executed.
module sequencer_rw_mgr_cmd_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  input  logic             keep_head,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; contents are don't-care until written, pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking, including the head-preserving flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        wr_ptr_r <= rd_ptr_r + PTR_ONE;
        count_r  <= CW'(0);
      end else if (keep_head && !empty) begin
        wr_ptr_r <= rd_ptr_r + PTR_ONE;
        count_r  <= CW'(1);
      end else begin
        wr_ptr_r <= rd_ptr_r;
        count_r  <= CW'(0);
      end
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sequencer_rw_mgr_cmd_queue.sv
// Avalon-MM slave front-end for the rw_mgr core: queued command dispatch,
// ordered core reads, STATUS/CTRL register and a done-timeout watchdog.
module sequencer_rw_mgr_cmd_queue
  import sequencer_rw_mgr_pkg::*;
#(
  parameter int AVL_DATA_WIDTH    = 32,
  parameter int AVL_ADDRESS_WIDTH = 16,
  parameter int CMD_FIFO_DEPTH    = 4,
  parameter int POSTED_WRITES     = 1,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                         avl_clk,
  input  logic                         avl_reset_n,
  input  logic [AVL_ADDRESS_WIDTH-1:0] avl_address,
  input  logic                         avl_write,
  input  logic [AVL_DATA_WIDTH-1:0]    avl_writedata,
  input  logic                         avl_read,
  output logic [AVL_DATA_WIDTH-1:0]    avl_readdata,
  output logic                         avl_waitrequest,
  output logic                         cmd_exec,
  output logic [AVL_ADDRESS_WIDTH-6:0] cmd_addr,
  output logic [AVL_DATA_WIDTH-1:0]    cmd_wdata,
  input  logic                         cmd_done,
  output logic                         config_reg_wr,
  output logic                         config_reg_rd,
  output logic                         param_rd,
  output logic                         cstate_rd,
  input  logic [AVL_DATA_WIDTH-1:0]    core_rdata
);

  localparam int AW  = AVL_ADDRESS_WIDTH;
  localparam int DW  = AVL_DATA_WIDTH;
  localparam int CAW = AW - 5;
  localparam int FW  = CAW + DW;
  localparam int CW  = $clog2(CMD_FIFO_DEPTH) + 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  region_e     region_s;
  disp_state_e disp_state_r, disp_next_s;
  rd_state_e   rd_state_r, rd_next_s;

  logic [FW-1:0] head_s;
  logic [CW-1:0] count_s;
  logic          full_s, empty_s, push_s, pop_s, flush_s, clr_s;
  logic          idle_all_s, to_hit_s, spur_s, cfg_wr_s, waitrequest_s;
  logic          np_pend_r, np_done_r, np_set_s, np_ack_s, np_last_pop_s;
  logic          timeout_r, spurious_r, rd_load_s, rd_wait_s;
  logic [TW-1:0] to_cnt_r;
  logic [DW-1:0] rd_data_s, status_s;

  assign region_s      = decode_region(avl_address[AW-1:AW-5]);
  assign idle_all_s    = empty_s && (disp_state_r == DISP_IDLE);
  assign flush_s       = avl_write && (region_s == RGN_STATUS) && avl_writedata[1];
  assign clr_s         = avl_write && (region_s == RGN_STATUS) && avl_writedata[0];
  assign np_last_pop_s = np_pend_r && pop_s && (count_s == CW'(1));

  sequencer_rw_mgr_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (CMD_FIFO_DEPTH),
    .CW    (CW)
  ) u_cmd_fifo (
    .clk       (avl_clk),
    .rst_n     (avl_reset_n),
    .push      (push_s),
    .wdata     ({avl_address[CAW-1:0], avl_writedata}),
    .pop       (pop_s),
    .flush     (flush_s),
    .keep_head (disp_state_r == DISP_EXEC),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Dispatcher next-state: issue head, retire on done or watchdog expiry.
  always_comb begin
    disp_next_s = disp_state_r;
    pop_s       = 1'b0;
    to_hit_s    = 1'b0;
    spur_s      = 1'b0;
    case (disp_state_r)
      DISP_IDLE: begin
        spur_s = cmd_done;
        if (!empty_s && !flush_s) begin
          disp_next_s = DISP_EXEC;
        end else begin
          disp_next_s = DISP_IDLE;
        end
      end
      DISP_EXEC: begin
        if (cmd_done) begin
          pop_s       = 1'b1;
          disp_next_s = DISP_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_r == TO_LAST)) begin
          pop_s       = 1'b1;
          to_hit_s    = 1'b1;
          disp_next_s = DISP_IDLE;
        end else begin
          disp_next_s = DISP_EXEC;
        end
      end
      default: disp_next_s = DISP_IDLE;
    endcase
  end

  // Dispatcher state and watchdog counter.
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      disp_state_r <= DISP_IDLE;
      to_cnt_r     <= '0;
    end else begin
      disp_state_r <= disp_next_s;
      if ((disp_state_r == DISP_EXEC) && (disp_next_s == DISP_EXEC)) begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_s                         = '0;
    status_s[ST_OCC_MSB:ST_OCC_LSB]  = 8'(count_s);
    status_s[ST_BUSY]                = !idle_all_s;
    status_s[ST_TIMEOUT]             = timeout_r;
    status_s[ST_SPURIOUS]            = spurious_r;
    status_s[ST_FULL]                = full_s;
  end

  // Avalon request handling: write acceptance, read FSM and wait-state generation.
  always_comb begin
    waitrequest_s = 1'b0;
    push_s        = 1'b0;
    cfg_wr_s      = 1'b0;
    np_set_s      = 1'b0;
    np_ack_s      = 1'b0;
    rd_next_s     = rd_state_r;
    rd_load_s     = 1'b0;
    rd_data_s     = '0;
    if (avl_write) begin
      rd_next_s = RD_IDLE;
      case (region_s)
        RGN_CMD: begin
          if (POSTED_WRITES != 0) begin
            push_s        = !full_s;
            waitrequest_s = full_s;
          end else if (np_done_r) begin
            np_ack_s = 1'b1;
          end else if (np_pend_r) begin
            waitrequest_s = 1'b1;
          end else begin
            push_s        = !full_s;
            np_set_s      = !full_s;
            waitrequest_s = 1'b1;
          end
        end
        RGN_CONFIG: begin
          if (idle_all_s) begin
            cfg_wr_s = 1'b1;
          end else begin
            waitrequest_s = 1'b1;
          end
        end
        default: waitrequest_s = 1'b0;
      endcase
    end else if (avl_read) begin
      case (rd_state_r)
        RD_IDLE: begin
          waitrequest_s = 1'b1;
          case (region_s)
            RGN_CMD, RGN_CONFIG, RGN_CSTATE: begin
              if (idle_all_s) begin
                rd_next_s = RD_WAIT;
              end else begin
                rd_next_s = RD_IDLE;
              end
            end
            RGN_STATUS: begin
              rd_load_s = 1'b1;
              rd_data_s = status_s;
              rd_next_s = RD_DONE;
            end
            default: begin
              rd_load_s = 1'b1;
              rd_data_s = '0;
              rd_next_s = RD_DONE;
            end
          endcase
        end
        RD_WAIT: begin
          waitrequest_s = 1'b1;
          rd_load_s     = 1'b1;
          rd_data_s     = core_rdata;
          rd_next_s     = RD_DONE;
        end
        RD_DONE: begin
          waitrequest_s = 1'b0;
          rd_next_s     = RD_IDLE;
        end
        default: rd_next_s = RD_IDLE;
      endcase
    end else begin
      rd_next_s = RD_IDLE;
    end
  end

  // Read FSM state and read data register; readdata holds between reads.
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      rd_state_r   <= RD_IDLE;
      avl_readdata <= '0;
    end else begin
      rd_state_r <= rd_next_s;
      if (rd_load_s) begin
        avl_readdata <= rd_data_s;
      end
    end
  end

  // Sticky error bits (set beats clear) and legacy blocking-write tracking.
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      timeout_r  <= 1'b0;
      spurious_r <= 1'b0;
      np_pend_r  <= 1'b0;
      np_done_r  <= 1'b0;
    end else begin
      timeout_r  <= to_hit_s ? 1'b1 : (clr_s ? 1'b0 : timeout_r);
      spurious_r <= spur_s ? 1'b1 : (clr_s ? 1'b0 : spurious_r);
      // The blocked entry is always the youngest, so it retires when the last entry pops.
      np_pend_r  <= np_set_s ? 1'b1 : (np_last_pop_s ? 1'b0 : np_pend_r);
      np_done_r  <= np_ack_s ? 1'b0 : (np_last_pop_s ? 1'b1 : np_done_r);
    end
  end

  assign rd_wait_s       = avl_read && !avl_write && (rd_state_r == RD_WAIT);
  assign param_rd        = rd_wait_s && (region_s == RGN_CMD);
  assign config_reg_rd   = rd_wait_s && (region_s == RGN_CONFIG);
  assign cstate_rd       = rd_wait_s && (region_s == RGN_CSTATE);
  assign config_reg_wr   = cfg_wr_s;
  assign avl_waitrequest = waitrequest_s;
  assign cmd_exec        = (disp_state_r == DISP_EXEC);
  assign cmd_addr        = cmd_exec ? head_s[FW-1:DW] : '0;
  assign cmd_wdata       = cmd_exec ? head_s[DW-1:0] : '0;

endmodule
